// File: rtl/onoc_token_client.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onoc_token_client: per-node ONoC transmit agent (FIFO + token FSM)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module onoc_token_client #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   input  logic                     grant,
   output logic                     request,
   output logic                     done,
   output logic                     tx_valid,
   output logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
   localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_BURST);
   localparam logic [AW:0]   OCC_ONE    = (AW+1)'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TX      = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];

   logic full, empty, enq, deq, drain;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign occupancy = wr_ptr_q - rd_ptr_q;
   assign in_ready  = !full;
   assign request   = !empty;
   assign enq       = in_valid && !full;
   assign deq       = tx_valid && tx_ready;
   assign drain     = (occupancy == OCC_ONE) && !enq;
   assign tx_data   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (enq) begin
         mem_d[wr_ptr_q[AW-1:0]] = in_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done     = 1'b0;
      tx_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               cnt_d   = '0;
               state_d = empty ? RELEASE : TX;
            end
         end
         TX: begin
            // Losing grant mid-burst withdraws the beat this very cycle
            if (!grant) begin
               state_d = IDLE;
            end else begin
               tx_valid = 1'b1;
               if (tx_ready) begin
                  if (cnt_q != BURST_MAX) begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if ((cnt_q == BURST_LAST) || drain) begin
                     state_d = RELEASE;
                  end
               end
            end
         end
         RELEASE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_onoc_token_client.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_onoc_token_client: directed self-checking bench                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_onoc_token_client;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        grant;
   logic        request;
   logic        done;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_ready;
   logic [3:0]  occupancy;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int overlap_cnt = 0;
   logic [31:0] beats [$];

   onoc_token_client #(.DATA_W(32), .DEPTH(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .grant     (grant),
      .request   (request),
      .done      (done),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done) done_cnt++;
      if (done && tx_valid) overlap_cnt++;
      if (tx_valid && tx_ready) beats.push_back(tx_data);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int d0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; grant = 1'b0; tx_ready = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_request", request, 0);
      chk("rst_done", done, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_occ", occupancy, 0);

      // single packet
      in_valid = 1'b1; in_data = 32'hA5A5_0001;
      cyc();
      in_valid = 1'b0;
      #1;
      chk("sp_occ1", occupancy, 1);
      chk("sp_request", request, 1);
      grant = 1'b1; tx_ready = 1'b1;
      cyc();
      chk("sp_tx_valid", tx_valid, 1);
      chk("sp_tx_data", tx_data, 32'hA5A5_0001);
      chk("sp_no_done", done, 0);
      cyc();
      chk("sp_done", done, 1);
      chk("sp_tx_valid_off", tx_valid, 0);
      chk("sp_occ0", occupancy, 0);
      grant = 1'b0;
      cyc();
      chk("sp_done_off", done, 0);

      // empty pass-through
      d0 = done_cnt;
      grant = 1'b1;
      cyc();
      chk("ep_done", done, 1);
      chk("ep_tx_valid", tx_valid, 0);
      chk("ep_request", request, 0);
      grant = 1'b0;
      cyc();
      chk("ep_done_off", done, 0);
      chk("ep_one_pulse", done_cnt - d0, 1);

      // burst limit
      for (int i = 1; i <= 6; i++) begin
         in_valid = 1'b1; in_data = i;
         cyc();
      end
      in_valid = 1'b0;
      #1;
      chk("bl_occ6", occupancy, 6);
      grant = 1'b1; tx_ready = 1'b1;
      cyc();
      for (int k = 1; k <= 4; k++) begin
         chk("bl_tx_valid", tx_valid, 1);
         chk("bl_tx_data", tx_data, k);
         cyc();
      end
      chk("bl_done", done, 1);
      chk("bl_tx_valid_off", tx_valid, 0);
      chk("bl_occ2", occupancy, 2);
      grant = 1'b0;
      cyc();
      chk("bl_idle_done", done, 0);
      chk("bl_idle_tx_valid", tx_valid, 0);
      grant = 1'b1;
      cyc();
      chk("bl_tx5", tx_data, 5);
      chk("bl_tx5_valid", tx_valid, 1);
      cyc();
      chk("bl_tx6", tx_data, 6);
      cyc();
      chk("bl_done2", done, 1);
      chk("bl_occ0", occupancy, 0);
      grant = 1'b0;
      cyc();

      // backpressure
      beats.delete();
      in_valid = 1'b1; in_data = 32'hB1; cyc();
      in_data = 32'hB2; cyc();
      in_valid = 1'b0;
      grant = 1'b1; tx_ready = 1'b0;
      cyc();
      #1;
      chk("bp_c1_valid", tx_valid, 1);
      chk("bp_c1_data", tx_data, 32'hB1);
      cyc();
      tx_ready = 1'b1; #1;
      chk("bp_c2_data", tx_data, 32'hB1);
      cyc();
      tx_ready = 1'b0; #1;
      chk("bp_c3_data", tx_data, 32'hB2);
      chk("bp_c3_valid", tx_valid, 1);
      cyc();
      #1;
      chk("bp_c4_data", tx_data, 32'hB2);
      cyc();
      tx_ready = 1'b1; #1;
      chk("bp_c5_data", tx_data, 32'hB2);
      cyc();
      chk("bp_done", done, 1);
      chk("bp_beats", beats.size(), 2);
      if (beats.size() == 2) begin
         chk("bp_beat0", beats[0], 32'hB1);
         chk("bp_beat1", beats[1], 32'hB2);
      end
      grant = 1'b0;
      cyc();

      // reset mid-TX
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_data = 32'hC0 + i;
         cyc();
      end
      in_valid = 1'b0;
      grant = 1'b1; tx_ready = 1'b1;
      cyc();
      chk("rm_tx_valid", tx_valid, 1);
      chk("rm_tx_data", tx_data, 32'hC1);
      d0 = done_cnt;
      rst = 1'b1;
      cyc();
      rst = 1'b0; grant = 1'b0;
      #1;
      chk("rm_occ", occupancy, 0);
      chk("rm_tx_valid_off", tx_valid, 0);
      chk("rm_done", done, 0);
      chk("rm_in_ready", in_ready, 1);
      cyc();
      chk("rm_done_later", done, 0);
      chk("rm_no_pulse", done_cnt - d0, 0);

      // full FIFO
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 32'hF0 + i;
         cyc();
      end
      chk("ff_in_ready", in_ready, 0);
      chk("ff_occ8", occupancy, 8);
      in_data = 32'h99;
      cyc();
      chk("ff_ninth_blocked", occupancy, 8);
      grant = 1'b1;
      cyc();
      chk("ff_tx_valid", tx_valid, 1);
      chk("ff_head", tx_data, 32'hF0);
      chk("ff_occ_still8", occupancy, 8);
      cyc();
      chk("ff_occ7", occupancy, 7);
      chk("ff_in_ready_back", in_ready, 1);
      chk("ff_head_next", tx_data, 32'hF1);
      in_valid = 1'b0;
      grant = 1'b0;
      #1;
      chk("gd_tx_valid_gated", tx_valid, 0);
      cyc();
      chk("gd_no_done", done, 0);
      chk("gd_occ7", occupancy, 7);
      cyc();
      chk("gd_no_done2", done, 0);
      chk("no_done_tx_overlap", overlap_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
